// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: divide op encoding, divider FSM states and
// the decoder constants that identify a multiply/divide instruction.
package rv32m_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/divider_unit_if.sv
// Execute-stage divider bus: operands in, result plus stall/valid out.
interface divider_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             div_stall;
  logic             busy;

  modport master (
    output start, op, dividend, divisor,
    input  result, result_valid, div_stall, busy
  );

  modport slave (
    input  start, op, dividend, divisor,
    output result, result_valid, div_stall, busy
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on a WIDTH+1 bit shifted remainder.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_next,
  output logic [WIDTH-1:0] o_quo_next
);
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, i_divisor};
  // rem < divisor on entry, so the borrow bit alone tells whether it fits
  assign w_ge     = ~w_diff[WIDTH];

  assign o_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign o_quo_next = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/divider_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) that stalls the front end
// while a divide is in flight and presents the result for one cycle.
module divider_unit
  import rv32m_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  divider_unit_if.slave  bus
);
  localparam int unsigned CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state, w_state_next;
  div_op_t          w_op, r_op;
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_rem, r_quo, r_div, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_result_valid, r_busy;
  logic             w_stall;

  logic             w_signed, w_is_rem, w_a_neg, w_b_neg;
  logic             w_div_zero, w_overflow, w_special;
  logic [WIDTH-1:0] w_a_abs, w_b_abs, w_special_res;
  logic [WIDTH-1:0] w_rem_next, w_quo_next, w_quo_fix, w_rem_fix, w_final;

  // Decode of the incoming instruction, only meaningful in IDLE with start
  assign w_op       = div_op_t'(bus.op);
  assign w_signed   = (w_op == DIV) || (w_op == REM);
  assign w_is_rem   = (w_op == REM) || (w_op == REMU);
  assign w_a_neg    = w_signed & bus.dividend[WIDTH-1];
  assign w_b_neg    = w_signed & bus.divisor[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_b_abs    = w_b_neg ? -bus.divisor  : bus.divisor;
  assign w_div_zero = (bus.divisor == '0);
  assign w_overflow = w_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  assign w_special  = w_div_zero | w_overflow;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero)      w_special_res = w_is_rem ? bus.dividend : '1;
    else if (w_overflow) w_special_res = w_is_rem ? '0 : MIN_NEG;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem      (r_rem),
    .i_quo      (r_quo),
    .i_divisor  (r_div),
    .o_rem_next (w_rem_next),
    .o_quo_next (w_quo_next)
  );

  assign w_quo_fix = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_rem_fix = r_neg_r ? -w_rem_next : w_rem_next;
  assign w_final   = ((r_op == REM) || (r_op == REMU)) ? w_rem_fix : w_quo_fix;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and the combinational stall
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_stall      = 1'b1;
          w_state_next = w_special ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op           <= DIV;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_div          <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_result_valid <= (w_state_next == DONE);
      r_busy         <= (w_state_next != IDLE);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op    <= w_op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_rem   <= '0;
            r_quo   <= w_a_abs;
            r_div   <= w_b_abs;
            r_cnt   <= w_special ? '0 : CNT_W'(WIDTH);
            if (w_special) r_result <= w_special_res;
          end
        end
        BUSY: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign bus.div_stall    = rst_n & w_stall;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed divides plus a cycle-level
// reference model of stall/valid/busy timing and RISC-V division results.
module tb_divider_unit;
  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  divider_unit_if #(.WIDTH(32)) bus ();
  divider_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // RISC-V M-extension division semantics in plain arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0:    return ovf ? a : 32'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Compare process: timeline of the current divide, checked every cycle
  bit          m_active = 1'b0;
  int          m_k, m_lat;
  logic [31:0] m_res;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("stall_in_reset", 32'(bus.div_stall), 32'd0);
      m_active = 1'b0;
    end else begin
      if (!m_active && bus.start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_lat    = ref_lat(bus.op, bus.dividend, bus.divisor);
        m_res    = ref_res(bus.op, bus.dividend, bus.divisor);
      end
      chk("model_stall", 32'(bus.div_stall), 32'(m_active && m_k < m_lat));
      chk("model_valid", 32'(bus.result_valid), 32'(m_active && m_k == m_lat));
      chk("model_busy",  32'(bus.busy), 32'(m_active && m_k >= 1));
      if (m_active && m_k == m_lat) begin
        chk("model_result", bus.result, m_res);
        m_active = 1'b0;
      end else if (m_active) begin
        m_k++;
      end
    end
  end

  // Present one divide (start left high) and wait for its result
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit got;
    logic [31:0] res;
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
    n = 0; got = 1'b0; res = '0;
    while (!got && n <= 100) begin
      @(negedge clk);
      if (bus.result_valid) begin got = 1'b1; res = bus.result; end
      else n++;
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s_timeout: no result_valid within 100 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(n), 32'(exp_lat));
      chk({name, "_result"}, res, exp_res);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    bus.start = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 32'd0);
    chk("reset_valid",  32'(bus.result_valid), 32'd0);
    chk("reset_busy",   32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    chk("pin_divu_100_7", ref_res(2'd1, 32'd100, 32'd7), 32'd14);
    chk("pin_div_m7_2",   ref_res(2'd0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem_7_m2",   ref_res(2'd2, 32'd7, 32'hFFFF_FFFE), 32'd1);
    chk("pin_rem_ovf",    ref_res(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    do_op("divu_100_7", 2'd1, 32'd100, 32'd7, 32'd14, 33);       idle(2);
    do_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 33);        idle(2);
    do_op("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33); idle(1);
    do_op("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33); idle(1);
    do_op("rem_7_m2",   2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);  idle(1);
    do_op("divu_5_0",   2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);   idle(1);
    do_op("remu_5_0",   2'd3, 32'd5, 32'd0, 32'd5, 1);           idle(1);
    do_op("div_ovf",    2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); idle(1);
    do_op("rem_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);         idle(1);
    do_op("div_big",    2'd0, 32'h8000_0000, 32'd3, 32'hD555_5556, 33);        idle(1);

    // Reset in BUSY cycle 10 with start still high; no result may appear
    bus.start = 1'b1; bus.op = 2'd1; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.start = 1'b0;
    chk("post_reset_stall", 32'(bus.div_stall), 32'd0);
    chk("post_reset_busy",  32'(bus.busy), 32'd0);
    chk("post_reset_valid", 32'(bus.result_valid), 32'd0);
    idle(3);
    do_op("divu_9_3", 2'd1, 32'd9, 32'd3, 32'd3, 33);

    // Back-to-back: second divide enters E the cycle after the first DONE
    do_op("b2b_divu_20_4", 2'd1, 32'd20, 32'd4, 32'd5, 33);
    do_op("b2b_remu_20_6", 2'd3, 32'd20, 32'd6, 32'd2, 33);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
